// File: rtl/tqvp_pat_sched_pkg.sv
// Shared definitions for the watchdog pat scheduler peripheral.
// Contents:
//   state_e      - scheduler state encoding, which software reads back through STATUS
//   ADDR_*       - word addresses of the peripheral registers
//   STATUS_*     - bit positions inside the STATUS register
//   bus_mask()   - byte-lane mask that matches the access width of a bus write
package tqvp_pat_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ARMED   = 3'd2,
    ST_PAT     = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_TASK_MASK = 6'h01;
  localparam logic [5:0] ADDR_CHECKIN   = 6'h02;
  localparam logic [5:0] ADDR_STATUS    = 6'h03;
  localparam logic [5:0] ADDR_DEADLINE  = 6'h04;
  localparam logic [5:0] ADDR_MISSED    = 6'h05;
  localparam logic [5:0] ADDR_PAT_COUNT = 6'h06;

  localparam int STATUS_ARMED_BIT = 0;
  localparam int STATUS_STATE_LSB = 1;
  localparam int STATUS_FAULT_BIT = 4;

  // data_write_n: 00 = byte, 01 = halfword, 10 = word. Bits above the access width are dropped.
  function automatic logic [31:0] bus_mask(input logic [1:0] wn);
    case (wn)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/pat_sched_deadline_ctr.sv
// Per-round deadline counter for the pat scheduler.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   clr         - return the count to zero (highest priority)
//   hold        - freeze the count
//   en          - increment the count by one
//   deadline    - cycles allowed per round; 0 disables the deadline
//   hit         - high in the last cycle of the round (count == deadline-1)
module pat_sched_deadline_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hold,
  input  logic             en,
  input  logic [CNT_W-1:0] deadline,
  output logic             hit
);

  logic [CNT_W-1:0] count_r;

  // Round counter: clear beats hold, hold beats increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (hold) begin
      count_r <= count_r;
    end else if (en) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (deadline != {CNT_W{1'b0}}) &&
               (count_r == (deadline - {{(CNT_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/tqvp_stevej_pat_scheduler.sv
// TinyQV peripheral that pats the watchdog once every enabled task has checked in
// and the watchdog window is open; a missed deadline withholds the pat, records
// the late tasks in MISSED and raises the interrupt.
// Ports:
//   clk, rst_n         - clock and synchronous active-low reset
//   address            - register word address
//   data_in            - write data (masked to the access width)
//   data_write_n       - 11 = no write, otherwise write of width 8/16/32
//   data_read_n        - unused, reads are combinational
//   data_out           - read data for address
//   data_ready         - always 1
//   user_interrupt     - MISSED != 0 or fault set (registered)
//   wd_window_open     - watchdog window is open
//   wd_expired         - watchdog has expired
//   wd_pat             - one-cycle registered pat strobe
module tqvp_stevej_pat_scheduler
  import tqvp_pat_sched_pkg::*;
#(
  parameter int NUM_TASKS = 8,
  parameter int CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  input  logic        wd_window_open,
  input  logic        wd_expired,
  output logic        wd_pat
);

  localparam logic [NUM_TASKS-1:0] TASKS_ZERO = {NUM_TASKS{1'b0}};

  state_e               state_r, state_next_s;
  logic                 enable_r;
  logic [NUM_TASKS-1:0] task_mask_r;
  logic [NUM_TASKS-1:0] checked_r, checked_next_s;
  logic [CNT_W-1:0]     deadline_r;
  logic [NUM_TASKS-1:0] missed_r, missed_next_s, new_miss_s;
  logic [15:0]          pat_count_r;
  logic                 fault_r, fault_next_s;
  logic                 wd_pat_r, irq_r;
  logic                 pat_done_s;
  logic                 ctr_clr_s, ctr_hold_s, ctr_en_s, hit_s;

  logic                 write_s;
  logic [31:0]          wdata_s;
  logic                 wr_ctrl_s, wr_mask_s, wr_checkin_s, wr_deadline_s, wr_missed_s;
  logic [NUM_TASKS-1:0] checkin_bits_s, collect_s;
  logic                 complete_s;
  logic                 unused_s;

  assign unused_s       = ^data_read_n;
  assign write_s        = (data_write_n != 2'b11);
  assign wdata_s        = data_in & bus_mask(data_write_n);
  assign wr_ctrl_s      = write_s && (address == ADDR_CTRL);
  assign wr_mask_s      = write_s && (address == ADDR_TASK_MASK);
  assign wr_checkin_s   = write_s && (address == ADDR_CHECKIN);
  assign wr_deadline_s  = write_s && (address == ADDR_DEADLINE);
  assign wr_missed_s    = write_s && (address == ADDR_MISSED);

  // Check-in bits arriving this cycle are folded in before the completion test,
  // so a task that checks in on the deadline cycle still counts as on time.
  assign checkin_bits_s = wr_checkin_s ? (wdata_s[NUM_TASKS-1:0] & task_mask_r) : TASKS_ZERO;
  assign collect_s      = checked_r | checkin_bits_s;
  assign complete_s     = (task_mask_r != TASKS_ZERO) && ((collect_s & task_mask_r) == task_mask_r);

  pat_sched_deadline_ctr #(.CNT_W(CNT_W)) u_deadline_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ctr_clr_s),
    .hold     (ctr_hold_s),
    .en       (ctr_en_s),
    .deadline (deadline_r),
    .hit      (hit_s)
  );

  // Next-state and round bookkeeping; a disable write overrides every state.
  always_comb begin
    state_next_s   = state_r;
    checked_next_s = checked_r;
    fault_next_s   = fault_r;
    new_miss_s     = TASKS_ZERO;
    pat_done_s     = 1'b0;
    ctr_clr_s      = 1'b0;
    ctr_hold_s     = 1'b1;
    ctr_en_s       = 1'b0;
    if (wr_ctrl_s && (wdata_s[0] == 1'b0)) begin
      state_next_s   = ST_IDLE;
      fault_next_s   = 1'b0;
      checked_next_s = TASKS_ZERO;
      ctr_clr_s      = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          checked_next_s = TASKS_ZERO;
          ctr_clr_s      = 1'b1;
          if (wr_ctrl_s) begin
            state_next_s = ST_COLLECT;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (wd_expired) begin
            state_next_s = ST_FAULT;
            fault_next_s = 1'b1;
          end else if (complete_s) begin
            state_next_s   = ST_ARMED;
            checked_next_s = collect_s;
          end else if (hit_s) begin
            new_miss_s     = task_mask_r & ~collect_s;
            checked_next_s = TASKS_ZERO;
            ctr_clr_s      = 1'b1;
          end else begin
            checked_next_s = collect_s;
            ctr_hold_s     = 1'b0;
            ctr_en_s       = 1'b1;
          end
        end
        ST_ARMED: begin
          if (wd_expired) begin
            state_next_s = ST_FAULT;
            fault_next_s = 1'b1;
          end else if (wd_window_open) begin
            state_next_s = ST_PAT;
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_PAT: begin
          // The strobe is already on the wire this cycle, so it is counted even if
          // the watchdog reports expiry at the same time.
          pat_done_s     = 1'b1;
          checked_next_s = TASKS_ZERO;
          ctr_clr_s      = 1'b1;
          if (wd_expired) begin
            state_next_s = ST_FAULT;
            fault_next_s = 1'b1;
          end else begin
            state_next_s = ST_COLLECT;
          end
        end
        ST_FAULT: begin
          state_next_s = ST_FAULT;
        end
        default: begin
          state_next_s   = ST_IDLE;
          checked_next_s = TASKS_ZERO;
          ctr_clr_s      = 1'b1;
        end
      endcase
    end
  end

  // W1C clear first, then fresh misses OR in so a same-cycle miss survives.
  assign missed_next_s = (missed_r & ~(wr_missed_s ? wdata_s[NUM_TASKS-1:0] : TASKS_ZERO)) | new_miss_s;

  // State, register file, pat strobe and interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      enable_r    <= 1'b0;
      task_mask_r <= TASKS_ZERO;
      checked_r   <= TASKS_ZERO;
      deadline_r  <= {CNT_W{1'b0}};
      missed_r    <= TASKS_ZERO;
      pat_count_r <= 16'd0;
      fault_r     <= 1'b0;
      wd_pat_r    <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      enable_r    <= wr_ctrl_s ? wdata_s[0] : enable_r;
      task_mask_r <= (wr_mask_s && !enable_r) ? wdata_s[NUM_TASKS-1:0] : task_mask_r;
      checked_r   <= checked_next_s;
      deadline_r  <= (wr_deadline_s && !enable_r) ? wdata_s[CNT_W-1:0] : deadline_r;
      missed_r    <= missed_next_s;
      pat_count_r <= pat_done_s ? (pat_count_r + 16'd1) : pat_count_r;
      fault_r     <= fault_next_s;
      wd_pat_r    <= (state_next_s == ST_PAT);
      irq_r       <= (missed_next_s != TASKS_ZERO) || fault_next_s;
    end
  end

  assign wd_pat         = wd_pat_r;
  assign user_interrupt = irq_r;
  assign data_ready     = 1'b1;

  logic [31:0] mask_word_s, checked_word_s, missed_word_s, deadline_word_s, status_word_s;

  // Zero-extend the narrow registers to the 32-bit bus.
  always_comb begin
    mask_word_s     = 32'h0;
    checked_word_s  = 32'h0;
    missed_word_s   = 32'h0;
    deadline_word_s = 32'h0;
    status_word_s   = 32'h0;
    mask_word_s[NUM_TASKS-1:0]    = task_mask_r;
    checked_word_s[NUM_TASKS-1:0] = checked_r;
    missed_word_s[NUM_TASKS-1:0]  = missed_r;
    deadline_word_s[CNT_W-1:0]    = deadline_r;
    status_word_s[STATUS_ARMED_BIT]       = (state_r == ST_ARMED);
    status_word_s[STATUS_STATE_LSB +: 3]  = state_r;
    status_word_s[STATUS_FAULT_BIT]       = fault_r;
  end

  // Combinational read mux.
  always_comb begin
    case (address)
      ADDR_CTRL:      data_out = {31'd0, enable_r};
      ADDR_TASK_MASK: data_out = mask_word_s;
      ADDR_CHECKIN:   data_out = checked_word_s;
      ADDR_STATUS:    data_out = status_word_s;
      ADDR_DEADLINE:  data_out = deadline_word_s;
      ADDR_MISSED:    data_out = missed_word_s;
      ADDR_PAT_COUNT: data_out = {16'd0, pat_count_r};
      default:        data_out = 32'h0;
    endcase
  end

endmodule

// File: doc/tqvp_stevej_pat_scheduler.md
Name: tqvp_stevej_pat_scheduler

Overview:
TinyQV peripheral that decides when the watchdog is patted, based on the software tasks it tracks. Each enabled task writes a check-in bit. Once every enabled task has checked in and the watchdog window is open, the block issues a one-cycle pat strobe to the watchdog. If a task misses its deadline, the block withholds the pat, latches which tasks missed, and raises an interrupt.

Parameters:
NUM_TASKS, 8, number of tracked tasks; legal range 1..32.
CNT_W, 32, width of the deadline counter and the DEADLINE register.

Ports:
clk  input  1  clock
rst_n  input  1  reset
address  input  6  register address within the peripheral
data_in  input  32  write data; bits above the bus access width are ignored
data_write_n  input  2  11 = no write; any other value = write
data_read_n  input  2  unused; reads are combinational
data_out  output  32  read data for the current address
data_ready  output  1  tied to 1
user_interrupt  output  1  level-high when MISSED is non-zero or FAULT is set
wd_window_open  input  1  watchdog status: timer has passed window_open
wd_expired  input  1  watchdog status: timer expired
wd_pat  output  1  one-cycle pat strobe to the watchdog
Interface decision: reset rst_n, synchronous, active-low; clock clk.

Behaviour:
- Registers, word addresses:
  - 0x0 CTRL (R/W): bit0 = enable.
  - 0x1 TASK_MASK (R/W): NUM_TASKS bits. Writes are ignored while enable=1.
  - 0x2 CHECKIN: write ORs data_in[NUM_TASKS-1:0] & TASK_MASK into CHECKED. Reads return CHECKED.
  - 0x3 STATUS (R): {27'b0, fault, state[2:0], armed}.
  - 0x4 DEADLINE (R/W): cycles allowed per round. Writes are ignored while enable=1.
  - 0x5 MISSED: read returns MISSED; write is write-1-to-clear.
  - 0x6 PAT_COUNT (R): 16-bit count of pats issued; wraps 0xFFFF -> 0.
  - All other addresses read 0.
- Reset values: all registers 0; state=IDLE; wd_pat=0; user_interrupt=0.
- State encoding: IDLE=0, COLLECT=1, ARMED=2, PAT=3, FAULT=4.
- IDLE:
  - CHECKED=0, counter=0.
  - A CTRL write with enable=1 moves to COLLECT on the next cycle.
- COLLECT:
  - Counter increments by 1 each cycle.
  - Completion test uses CHECKED_next, so a same-cycle check-in counts.
  - If TASK_MASK != 0 and (CHECKED_next & TASK_MASK) == TASK_MASK: go to ARMED and freeze the counter.
  - Else if counter == DEADLINE-1: MISSED |= TASK_MASK & ~CHECKED_next; CHECKED=0; counter=0; stay in COLLECT. No pat is issued.
  - If completion and deadline occur in the same cycle, completion wins.
  - DEADLINE=0 disables the deadline check.
  - TASK_MASK=0: the block never arms and never misses.
- ARMED:
  - Waits for wd_window_open=1, then goes to PAT. There is no timeout while ARMED.
  - Check-in writes while ARMED are ignored.
- PAT:
  - wd_pat=1 for exactly this one cycle.
  - PAT_COUNT++, CHECKED=0, counter=0; next state is COLLECT.
  - Latency: window open seen in cycle N gives wd_pat high in cycle N+1.
- FAULT entry:
  - wd_expired=1 in COLLECT, ARMED or PAT: go to FAULT next cycle and set the fault bit.
  - The fault bit takes priority over any other transition.
- FAULT: sticky; wd_pat is held at 0.
- Disable: a CTRL write with enable=0 from any state goes to IDLE next cycle and clears fault, CHECKED and the counter. MISSED is preserved.
- Bus write vs. internal update in the same cycle: the MISSED W1C clear applies first, then new miss bits OR in, so a new miss is never lost.
- Reset mid-round: everything returns to reset values and wd_pat drops immediately on the next edge.
- wd_pat is registered and never asserts in IDLE or FAULT.

Decomposition:
- Package tqvp_pat_sched_pkg:
  - state enum (IDLE, COLLECT, ARMED, PAT, FAULT);
  - address localparams ADDR_CTRL .. ADDR_PAT_COUNT;
  - STATUS bit positions.
- One sub-module, pat_sched_deadline_ctr:
  - CNT_W counter with clear, hold and enable inputs;
  - hit output asserted when count == DEADLINE-1 and DEADLINE != 0.
- The register file and FSM stay in the top module.

Test Plan:
1. TASK_MASK=0x3, DEADLINE=100, enable; CHECKIN 0x1 at cycle 10 and 0x2 at cycle 20; wd_window_open=1 from cycle 30 -> wd_pat high exactly one cycle at 31, PAT_COUNT=1, CHECKED=0, state=COLLECT.
2. TASK_MASK=0x7, DEADLINE=50, only task 0 checks in -> at cycle 50 MISSED=0x6, user_interrupt=1, no wd_pat; writing 0x6 to MISSED clears it and drops user_interrupt.
3. Completing CHECKIN write lands in the same cycle as the deadline hit -> ARMED, MISSED stays 0.
4. While ARMED, raise wd_expired -> state=FAULT, fault=1, user_interrupt=1, wd_pat never pulses; write CTRL=0 -> IDLE, fault=0.
5. Writes to TASK_MASK and DEADLINE while enabled -> values unchanged on readback; same writes while disabled -> take effect.
6. Assert rst_n=0 during ARMED with MISSED=0x1 -> all registers read 0, wd_pat=0, user_interrupt=0.
